// File: rtl/can_pkg.sv
// Shared CAN constants and the TX CRC state encoding.
package can_pkg;

  localparam int unsigned CAN_CRC_WIDTH = 15;
  // x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 with the implicit x^15 term dropped
  localparam logic [CAN_CRC_WIDTH-1:0] CAN_CRC_POLY = 15'h4599;

  localparam logic BIT_RECESSIVE = 1'b1;
  localparam logic BIT_DOMINANT  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_CRC_SEQ = 2'd2,
    ST_DELIM   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/can_crc_lfsr.sv
// One-bit-per-step CAN CRC LFSR. Shared between the TX and RX CRC paths.
module can_crc_lfsr import can_pkg::*; #(
  parameter int unsigned          CRC_WIDTH = CAN_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CAN_CRC_POLY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 data_in,
  output logic [CRC_WIDTH-1:0] crc
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_d;
  logic                 feedback;

  // Next CRC: clear wins over a step; otherwise hold.
  always_comb begin
    feedback = data_in ^ crc_q[CRC_WIDTH-1];
    crc_d    = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[CRC_WIDTH-2:0], BIT_DOMINANT} ^ (feedback ? CRC_POLY : '0);
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_crc_tx.sv
// CAN TX CRC engine: passes protected frame bits through while accumulating
// the CRC, then emits the CRC sequence MSB-first and the recessive delimiter.
module can_crc_tx import can_pkg::*; #(
  parameter int unsigned          CRC_WIDTH = CAN_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CAN_CRC_POLY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_tick,
  input  logic                 frame_start,
  input  logic                 data_in,
  input  logic                 data_last,
  input  logic                 abort,
  output logic                 tx_bit,
  output logic                 tx_valid,
  output logic                 stuff_en,
  output logic                 busy,
  output logic                 done,
  output logic [CRC_WIDTH-1:0] crc_value
);

  localparam int unsigned          CNT_W    = $clog2(CRC_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(CRC_WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_valid_q, tx_valid_d;
  logic             stuff_en_q, stuff_en_d;
  logic             done_q, done_d;
  // Distinguishes the delimiter bit time from the tick that closes it.
  logic             delim_seen_q, delim_seen_d;
  logic             lfsr_en;
  logic             lfsr_clr;

  can_crc_lfsr #(
    .CRC_WIDTH (CRC_WIDTH),
    .CRC_POLY  (CRC_POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (lfsr_en),
    .clear   (lfsr_clr),
    .data_in (data_in),
    .crc     (crc_value)
  );

  // Next-state and output logic; abort > frame_start > bit_tick.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_valid_d   = tx_valid_q;
    stuff_en_d   = stuff_en_q;
    done_d       = 1'b0;
    delim_seen_d = delim_seen_q;
    lfsr_en      = 1'b0;
    lfsr_clr     = 1'b0;

    if (abort) begin
      // CRC is left untouched so the aborted value stays observable.
      state_d      = ST_IDLE;
      cnt_d        = CNT_INIT;
      tx_bit_d     = BIT_RECESSIVE;
      tx_valid_d   = 1'b0;
      stuff_en_d   = 1'b0;
      delim_seen_d = 1'b0;
    end else if (frame_start) begin
      // A coincident bit_tick is dropped: the new frame starts clean.
      state_d      = ST_ACCUM;
      cnt_d        = CNT_INIT;
      tx_bit_d     = BIT_RECESSIVE;
      tx_valid_d   = 1'b0;
      stuff_en_d   = 1'b0;
      delim_seen_d = 1'b0;
      lfsr_clr     = 1'b1;
    end else if (bit_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          // Nothing to send; outputs already hold idle values.
        end
        ST_ACCUM: begin
          tx_bit_d   = data_in;
          tx_valid_d = 1'b1;
          stuff_en_d = 1'b1;
          lfsr_en    = 1'b1;
          if (data_last) begin
            state_d = ST_CRC_SEQ;
          end
        end
        ST_CRC_SEQ: begin
          tx_bit_d   = crc_value[cnt_q];
          tx_valid_d = 1'b1;
          stuff_en_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_DELIM;
            cnt_d   = CNT_INIT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DELIM: begin
          tx_bit_d   = BIT_RECESSIVE;
          stuff_en_d = 1'b0;
          if (!delim_seen_q) begin
            tx_valid_d   = 1'b1;
            delim_seen_d = 1'b1;
          end else begin
            tx_valid_d   = 1'b0;
            done_d       = 1'b1;
            delim_seen_d = 1'b0;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_INIT;
      tx_bit_q     <= BIT_RECESSIVE;
      tx_valid_q   <= 1'b0;
      stuff_en_q   <= 1'b0;
      done_q       <= 1'b0;
      delim_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_valid_q   <= tx_valid_d;
      stuff_en_q   <= stuff_en_d;
      done_q       <= done_d;
      delim_seen_q <= delim_seen_d;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign stuff_en = stuff_en_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_crc_tx.sv
// Directed + randomized bench for can_crc_tx against a polynomial-division CRC model.
module tb_can_crc_tx;
  import can_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n = 1'b0;
  logic        bit_tick = 1'b0;
  logic        frame_start = 1'b0;
  logic        data_in = 1'b0;
  logic        data_last = 1'b0;
  logic        abort = 1'b0;
  logic        tx_bit;
  logic        tx_valid;
  logic        stuff_en;
  logic        busy;
  logic        done;
  logic [14:0] crc_value;

  int checks = 0;
  int errors = 0;
  logic msg_q[$];

  can_crc_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_tick    (bit_tick),
    .frame_start (frame_start),
    .data_in     (data_in),
    .data_last   (data_last),
    .abort       (abort),
    .tx_bit      (tx_bit),
    .tx_valid    (tx_valid),
    .stuff_en    (stuff_en),
    .busy        (busy),
    .done        (done),
    .crc_value   (crc_value)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of (message * x^15) divided by the 16-bit generator.
  function automatic logic [14:0] crc_model();
    logic [15:0] rem = 16'h0;
    int n = msg_q.size();
    for (int i = 0; i < n + 15; i++) begin
      rem = {rem[14:0], (i < n) ? msg_q[i] : 1'b0};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    return rem[14:0];
  endfunction

  task automatic tick(input logic d, input logic last);
    @(posedge clk); #1;
    bit_tick = 1'b1; data_in = d; data_last = last;
    @(posedge clk); #1;
    bit_tick = 1'b0; data_last = 1'b0;
  endtask

  task automatic fstart();
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  // Sends msg_q on an already-armed frame and checks every bit time.
  task automatic send_body(output logic [14:0] crc_exp);
    int   n = msg_q.size();
    logic e;
    crc_exp = crc_model();
    for (int i = 0; i < n + 16; i++) begin
      if (i < n)           e = msg_q[i];
      else if (i < n + 15) e = crc_exp[14 - (i - n)];
      else                 e = BIT_RECESSIVE;
      if (i < n) tick(msg_q[i], i == n - 1);
      else       tick(1'($urandom), 1'($urandom));
      chk("tx_bit", 16'(tx_bit), 16'(e));
      chk("tx_valid", 16'(tx_valid), 16'h1);
      chk("stuff_en", 16'(stuff_en), 16'(i < n + 15));
      chk("done_early", 16'(done), 16'h0);
      chk("busy_frame", 16'(busy), 16'h1);
      if (i >= n - 1) chk("crc_frozen", 16'(crc_value), 16'(crc_exp));
    end
    tick(1'($urandom), 1'b0);
    chk("done_pulse", 16'(done), 16'h1);
    chk("busy_end", 16'(busy), 16'h0);
    chk("valid_end", 16'(tx_valid), 16'h0);
    chk("txbit_end", 16'(tx_bit), 16'h1);
    chk("stuff_end", 16'(stuff_en), 16'h0);
    @(posedge clk); #1;
    chk("done_once", 16'(done), 16'h0);
    chk("crc_hold", 16'(crc_value), 16'(crc_exp));
    $display("frame len=%0d crc=%04h", n, crc_exp);
  endtask

  initial begin
    logic [14:0] c;
    int len;

    // Reset values
    #12;
    chk("rst_txbit", 16'(tx_bit), 16'h1);
    chk("rst_valid", 16'(tx_valid), 16'h0);
    chk("rst_stuff", 16'(stuff_en), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_crc", 16'(crc_value), 16'h0);
    @(negedge clk); rst_n = 1'b1;

    // Ticks in IDLE do nothing
    tick(1'b0, 1'b1);
    chk("idle_valid", 16'(tx_valid), 16'h0);
    chk("idle_busy", 16'(busy), 16'h0);

    // Single-bit frame
    msg_q = {1'b1};
    fstart();
    chk("start_busy", 16'(busy), 16'h1);
    chk("start_crc", 16'(crc_value), 16'h0);
    chk("start_valid", 16'(tx_valid), 16'h0);
    send_body(c);
    chk("crc_single", 16'(crc_value), 16'h4599);

    // Two-bit frame
    msg_q = {1'b1, 1'b0};
    fstart();
    send_body(c);
    chk("crc_two", 16'(crc_value), 16'h4EAB);

    // All-zero 19-bit frame
    msg_q = {};
    for (int i = 0; i < 19; i++) msg_q.push_back(BIT_DOMINANT);
    fstart();
    send_body(c);
    chk("crc_zero", 16'(crc_value), 16'h0);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      len = int'($urandom_range(1, 40));
      msg_q = {};
      for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom));
      fstart();
      send_body(c);
    end

    // Abort after 5 CRC bits
    msg_q = {};
    for (int i = 0; i < 6; i++) msg_q.push_back(1'($urandom));
    c = crc_model();
    fstart();
    for (int i = 0; i < 6; i++) tick(msg_q[i], i == 5);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0);
      chk("abort_pre_crcbit", 16'(tx_bit), 16'(c[14 - k]));
    end
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_txbit", 16'(tx_bit), 16'h1);
    chk("abort_valid", 16'(tx_valid), 16'h0);
    chk("abort_stuff", 16'(stuff_en), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    chk("abort_crc", 16'(crc_value), 16'(c));
    for (int k = 0; k < 3; k++) begin
      tick(1'($urandom), 1'b0);
      chk("abort_nodone", 16'(done), 16'h0);
      chk("abort_novalid", 16'(tx_valid), 16'h0);
      chk("abort_crc_hold", 16'(crc_value), 16'(c));
    end
    $display("abort after 5 crc bits crc=%04h", c);

    // frame_start coincident with bit_tick mid-ACCUM
    fstart();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    @(posedge clk); #1;
    frame_start = 1'b1; bit_tick = 1'b1; data_in = 1'b1; data_last = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; bit_tick = 1'b0; data_last = 1'b0;
    chk("restart_crc", 16'(crc_value), 16'h0);
    chk("restart_valid", 16'(tx_valid), 16'h0);
    chk("restart_txbit", 16'(tx_bit), 16'h1);
    chk("restart_busy", 16'(busy), 16'h1);
    msg_q = {};
    for (int i = 0; i < 9; i++) msg_q.push_back(1'($urandom));
    send_body(c);

    // Async reset mid-ACCUM with the clock stopped
    fstart();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pre_rst_crc_nz", 16'(crc_value != 15'h0), 16'h1);
    @(negedge clk); clk_en = 1'b0;
    #2; rst_n = 1'b0;
    #1;
    chk("arst_txbit", 16'(tx_bit), 16'h1);
    chk("arst_valid", 16'(tx_valid), 16'h0);
    chk("arst_stuff", 16'(stuff_en), 16'h0);
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_crc", 16'(crc_value), 16'h0);
    $display("async reset with clock stopped");
    #2; rst_n = 1'b1;
    clk_en = 1'b1;
    tick(1'b1, 1'b1);
    chk("post_rst_idle", 16'(tx_valid), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
